picorv32_freeahb_bridge: RTL
============================

// Module: picorv32_freeahb_bridge
// PURPOSE
//  Parametrised successor to the PicoRV32-to-FreeAHB adapter. Sits between the PicoRV32 native
//  memory port and the FreeAHB ahb_master user port. Adds a posted-write buffer, wstrb-to-HSIZE
//  decode, splitting of non-contiguous strobes into byte transfers, and read-after-write ordering.
// PARAMETERS
//  WBUF_DEPTH      4        posted-write FIFO entries (power of 2, >=2); entry = {addr,wdata,wstrb}
//  TIMEOUT_CYCLES  1024     read watchdog limit in cycles (used only with PICO_AHB_TIMEOUT_EN)
//  ERR_RDATA       32'hDEADBEEF  read data returned on watchdog expiry
// PORTS
//  clk             in   1   clock
//  resetn          in   1   asynchronous active-low reset
//  mem_valid       in   1   PicoRV32 request valid; held with stable fields until mem_ready
//  mem_instr       in   1   request is an instruction fetch
//  mem_addr        in   32  byte address
//  mem_wdata       in   32  write data, lane-aligned
//  mem_wstrb       in   4   byte strobes; 0 = read
//  mem_ready       out  1   one-cycle completion pulse
//  mem_rdata       out  32  read data, valid with mem_ready
//  freeahb_valid   out  1   request to ahb_master i_valid
//  freeahb_addr    out  32  transfer byte address
//  freeahb_size    out  3   HSIZE: 0 byte, 1 half, 2 word
//  freeahb_write   out  1   write request
//  freeahb_read    out  1   read request
//  freeahb_wdata   out  32  write data, unmodified lanes
//  freeahb_min_len out  32  constant 1
//  freeahb_cont    out  1   constant 0 (single transfers only)
//  freeahb_prot    out  4   4'b0010 instr fetch, 4'b0011 data
//  freeahb_lock    out  1   constant 0
//  freeahb_next    in   1   ahb_master accepted current request
//  freeahb_rdata   in   32  read data
//  freeahb_ready   in   1   freeahb_rdata valid
//  wbuf_level      out  $clog2(WBUF_DEPTH)+1  buffered write count
//  timeout_err     out  1   sticky read-timeout flag
// BEHAVIOUR
//  Reset: all outputs 0 except freeahb_min_len=1. FIFO emptied, FSM IDLE. Buffered writes are discarded.
//  Reset may be asserted mid-transfer; the bridge then restarts clean.
//  Write accept: mem_valid & |wstrb & FIFO not full -> push; mem_ready pulses next cycle.
//  FIFO full -> no ready until a pop. Push and pop in the same cycle are allowed at full.
//  A held mem_valid is never pushed twice; a request is pushed once, then ready is pulsed.
//  FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE.
//   IDLE: FIFO non-empty -> WR_REQ (drain has priority). Pending read & FIFO empty -> RD_REQ.
//   WR_REQ: drive head piece. freeahb_next -> advance to next piece, or pop on last piece -> IDLE.
//   RD_REQ: read, size 2, addr[1:0]=0. freeahb_next -> RD_WAIT.
//   RD_WAIT: freeahb_ready -> capture rdata -> RD_DONE.
//   RD_DONE: mem_ready=1 for one cycle -> IDLE.
//  freeahb_valid and its fields are held stable until freeahb_next is sampled high.
//  Strobe decode, addr = {mem_addr[31:2],lane}:
//   1111 -> word, lane 0.
//   0011 -> half, lane 0.
//   1100 -> half, lane 2.
//   one-hot -> byte at that lane.
//   Any other pattern -> one byte transfer per set bit, ascending lane order, one piece per freeahb_next.
//  Reads wait for FIFO empty. This enforces read-after-write ordering to any address.
//  Minimum read latency, mem_valid to mem_ready = 4 cycles, with next and ready each one cycle after request.
// CONFIGURATION
//  PICO_AHB_TIMEOUT_EN defined:
//   - Counter clears on entering RD_WAIT; it increments each RD_WAIT cycle.
//   - Reaching TIMEOUT_CYCLES -> RD_DONE with mem_rdata=ERR_RDATA, and timeout_err set until reset.
//   - A late freeahb_ready for that read is ignored.
//  Not defined: RD_WAIT waits indefinitely, no counter logic, timeout_err tied 0.
// TESTING
//  - Read word, next and ready 1 cycle after request, rdata 32'hCAFEF00D -> mem_ready 1 cycle, mem_rdata CAFEF00D, prot 0010 if mem_instr.
//  - Write wstrb 1100 addr 0x80000004 -> mem_ready next cycle; one AHB write, size 1, addr 0x80000006.
//  - Write wstrb 0101 addr 0x100 -> two byte writes: addr 0x100 then 0x102; FIFO pops after second next.
//  - 5 back-to-back writes, next withheld, WBUF_DEPTH 4 -> wbuf_level 4, 5th stalls; released after first pop.
//  - Write to 0x200 then read 0x200 -> AHB write completes before read request issued.
//  - With PICO_AHB_TIMEOUT_EN, TIMEOUT_CYCLES 16, freeahb_ready never asserted -> mem_ready after 16 cycles, rdata DEADBEEF, timeout_err 1.

Source files
------------

// File: rtl/picorv32_freeahb_bridge.sv
// PicoRV32 native memory port to FreeAHB ahb_master user port bridge with posted writes.
// Optional read watchdog enabled by defining PICO_AHB_TIMEOUT_EN.
module picorv32_freeahb_bridge #(
  parameter int          WBUF_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          mem_valid,
  input  logic                          mem_instr,
  input  logic [31:0]                   mem_addr,
  input  logic [31:0]                   mem_wdata,
  input  logic [3:0]                    mem_wstrb,
  output logic                          mem_ready,
  output logic [31:0]                   mem_rdata,
  output logic                          freeahb_valid,
  output logic [31:0]                   freeahb_addr,
  output logic [2:0]                    freeahb_size,
  output logic                          freeahb_write,
  output logic                          freeahb_read,
  output logic [31:0]                   freeahb_wdata,
  output logic [31:0]                   freeahb_min_len,
  output logic                          freeahb_cont,
  output logic [3:0]                    freeahb_prot,
  output logic                          freeahb_lock,
  input  logic                          freeahb_next,
  input  logic [31:0]                   freeahb_rdata,
  input  logic                          freeahb_ready,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level,
  output logic                          timeout_err
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(WBUF_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t            state_reg, state_next;
  logic [31:0]       addr_mem [WBUF_DEPTH];
  logic [31:0]       data_mem [WBUF_DEPTH];
  logic [3:0]        strb_mem [WBUF_DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic [3:0]        done_reg;
  logic              wr_ack_reg;
  logic [31:0]       rd_addr_reg;
  logic              rd_instr_reg;
  logic [31:0]       rdata_reg;

  logic [31:0]       head_addr, head_data;
  logic [3:0]        head_strb, rem_strb, first_bit;
  logic [1:0]        piece_lane;
  logic [2:0]        piece_size;
  logic              piece_last;
  logic              full, push, pop, rd_start, rd_capture;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign head_strb = strb_mem[rd_ptr_reg];
  assign rem_strb  = head_strb & ~done_reg;

  // Lowest strobe bit not yet sent: the next byte piece of a split write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_first
      assign first_bit[gi] = rem_strb[gi] && ((rem_strb & ((4'd1 << gi) - 4'd1)) == 4'd0);
    end
  endgenerate

  always_comb begin
    piece_size = 3'd0;
    piece_lane = {first_bit[3] | first_bit[2], first_bit[3] | first_bit[1]};
    piece_last = ((rem_strb & ~first_bit) == 4'd0);
    case (head_strb)
      4'b1111: begin piece_size = 3'd2; piece_lane = 2'd0; piece_last = 1'b1; end
      4'b0011: begin piece_size = 3'd1; piece_lane = 2'd0; piece_last = 1'b1; end
      4'b1100: begin piece_size = 3'd1; piece_lane = 2'd2; piece_last = 1'b1; end
      default: ;
    endcase
  end

  assign full = (level_reg == LVL_FULL);
  assign pop  = (state_reg == WR_REQ) && freeahb_next && piece_last;
  // wr_ack_reg blocks a second push of the request still held during its ready pulse.
  assign push = mem_valid && (mem_wstrb != 4'd0) && !wr_ack_reg && (!full || pop);

`ifdef PICO_AHB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_err_reg;
  logic          rd_timeout;
`endif

  always_comb begin
    state_next    = state_reg;
    freeahb_valid = 1'b0;
    freeahb_write = 1'b0;
    freeahb_read  = 1'b0;
    freeahb_addr  = 32'd0;
    freeahb_size  = 3'd0;
    freeahb_wdata = 32'd0;
    freeahb_prot  = 4'd0;
    rd_start      = 1'b0;
    rd_capture    = 1'b0;
`ifdef PICO_AHB_TIMEOUT_EN
    rd_timeout    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          state_next = WR_REQ;
        end else if (mem_valid && (mem_wstrb == 4'd0)) begin
          state_next = RD_REQ;
          rd_start   = 1'b1;
        end
      end
      WR_REQ: begin
        freeahb_valid = 1'b1;
        freeahb_write = 1'b1;
        freeahb_addr  = (head_addr & 32'hFFFF_FFFC) | {30'd0, piece_lane};
        freeahb_size  = piece_size;
        freeahb_wdata = head_data;
        freeahb_prot  = 4'b0011;
        if (pop) state_next = IDLE;
      end
      RD_REQ: begin
        freeahb_valid = 1'b1;
        freeahb_read  = 1'b1;
        freeahb_addr  = rd_addr_reg & 32'hFFFF_FFFC;
        freeahb_size  = 3'd2;
        freeahb_prot  = {3'b001, ~rd_instr_reg};
        if (freeahb_next) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (freeahb_ready) begin
          state_next = RD_DONE;
          rd_capture = 1'b1;
        end
`ifdef PICO_AHB_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = RD_DONE;
          rd_timeout = 1'b1;
        end
`endif
      end
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      done_reg     <= 4'd0;
      wr_ack_reg   <= 1'b0;
      rd_addr_reg  <= 32'd0;
      rd_instr_reg <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg  <= state_next;
      wr_ack_reg <= push;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (push && !pop)      level_reg <= level_reg + LVL_ONE;
      else if (pop && !push) level_reg <= level_reg - LVL_ONE;
      if (state_reg == WR_REQ && freeahb_next)
        done_reg <= piece_last ? 4'd0 : (done_reg | first_bit);
      if (rd_start) begin
        rd_addr_reg  <= mem_addr;
        rd_instr_reg <= mem_instr;
      end
      if (rd_capture) rdata_reg <= freeahb_rdata;
`ifdef PICO_AHB_TIMEOUT_EN
      else if (rd_timeout) rdata_reg <= ERR_RDATA;
`endif
    end
  end

  // Buffer storage has no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= mem_addr;
      data_mem[wr_ptr_reg] <= mem_wdata;
      strb_mem[wr_ptr_reg] <= mem_wstrb;
    end
  end

`ifdef PICO_AHB_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_reg <= '0;
      tmo_err_reg <= 1'b0;
    end else begin
      if (state_reg == RD_REQ && freeahb_next) tmo_cnt_reg <= '0;
      else if (state_reg == RD_WAIT)           tmo_cnt_reg <= tmo_cnt_reg + TMO_ONE;
      if (rd_timeout) tmo_err_reg <= 1'b1;
    end
  end
  assign timeout_err = tmo_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem_ready       = wr_ack_reg | (state_reg == RD_DONE);
  assign mem_rdata       = rdata_reg;
  assign wbuf_level      = level_reg;
  assign freeahb_min_len = 32'd1;
  assign freeahb_cont    = 1'b0;
  assign freeahb_lock    = 1'b0;

endmodule
